// File: rtl/inv_mix_columns_iter_pkg.sv
`default_nettype none
// ============================================================================
// Module  : inv_mix_columns_iter_pkg
// Purpose : Shared AES column-mixing definitions. Holds the GF(2^8) reduction
//           polynomial, the InvMixColumns coefficient row, the FSM state
//           encoding and the constant-multiply helpers. The forward
//           MixColumns path reuses these definitions.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package inv_mix_columns_iter_pkg;

  localparam logic [8:0]  GF_POLY      = 9'h11B;
  // Row 0 of the InvMixColumns matrix; row r is this row rotated right by r.
  localparam logic [31:0] INV_MIX_ROW0 = 32'h0E0B0D09;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } fsm_state_t;

  // Multiply by x modulo the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? GF_POLY[7:0] : 8'h00);
  endfunction

  // Multiply by a constant: the loop unrolls into an xtime chain whose taps
  // are selected by the constant's bits, so no table is needed.
  function automatic logic [7:0] gf_mul_const(input logic [7:0] a,
                                              input logic [7:0] k);
    logic [7:0] acc;
    logic [7:0] pw;
    acc = '0;
    pw  = a;
    for (int i = 0; i < 8; i++) begin
      if (k[i]) acc = acc ^ pw;
      pw = xtime(pw);
    end
    return acc;
  endfunction

  // Coefficient m[r][k] of the inverse matrix.
  function automatic logic [7:0] inv_coef(input int r, input int k);
    int j;
    j = (k - r) & 3;
    return INV_MIX_ROW0[31-8*j -: 8];
  endfunction

endpackage
`default_nettype wire

// File: rtl/inv_mix_single_column.sv
`default_nettype none
// ============================================================================
// Module  : inv_mix_single_column
// Purpose : Purely combinational InvMixColumns of one 32-bit AES column.
// Ports   : col_in  [31:0] column, byte 0 in [31:24]
//           col_out [31:0] transformed column, same byte order
// Rev     : 1.0  initial release
// ============================================================================
module inv_mix_single_column
  import inv_mix_columns_iter_pkg::*;
(
  input  logic [31:0] col_in,
  output logic [31:0] col_out
);

  always_comb begin
    col_out = '0;
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 4; k++) begin
        col_out[31-8*r -: 8] = col_out[31-8*r -: 8]
                             ^ gf_mul_const(col_in[31-8*k -: 8], inv_coef(r, k));
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/inv_mix_columns_iter.sv
`default_nettype none
// ============================================================================
// Module  : inv_mix_columns_iter
// Purpose : Iterative AES InvMixColumns on a 128-bit state. A block is
//           captured in IDLE, transformed COLS_PER_CYCLE columns per cycle
//           in BUSY, and held in DONE until the consumer takes it.
// Ports   : clk        clock, rising edge
//           rst_n      asynchronous active-low reset
//           in_valid   / in_ready   input handshake
//           state_in   [127:0] input block, byte 0 in [127:120]
//           out_valid  / out_ready  output handshake
//           state_out  [127:0] result, same layout
// Rev     : 1.0  initial release
// ============================================================================
module inv_mix_columns_iter
  import inv_mix_columns_iter_pkg::*;
#(
  parameter int COLS_PER_CYCLE = 1
)
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out
);

  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4))
  begin : g_bad_cols_per_cycle
    $error("inv_mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  // Counter step and the base column of the final BUSY cycle. For 4 columns
  // per cycle both fold to 0 in two bits, which is harmless: the first BUSY
  // cycle is also the last.
  localparam logic [1:0] STEP      = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] LAST_BASE = 2'(4 - COLS_PER_CYCLE);

  fsm_state_t   state;
  logic [127:0] work;
  logic [127:0] work_next;
  logic [1:0]   col_cnt;

  logic [1:0]   col_idx [COLS_PER_CYCLE];
  logic [31:0]  col_cur [COLS_PER_CYCLE];
  logic [31:0]  col_new [COLS_PER_CYCLE];

  // Column c lives at bit offset (3-c)*32, i.e. {~c, 5'b0}.
  for (genvar i = 0; i < COLS_PER_CYCLE; i++) begin : g_col
    assign col_idx[i] = col_cnt + 2'(i);
    assign col_cur[i] = work[{~col_idx[i], 5'd0} +: 32];

    inv_mix_single_column u_col (
      .col_in  (col_cur[i]),
      .col_out (col_new[i])
    );
  end

  always_comb begin
    work_next = work;
    for (int i = 0; i < COLS_PER_CYCLE; i++) begin
      work_next[{~col_idx[i], 5'd0} +: 32] = col_new[i];
    end
  end

  // Gated by rst_n so the producer sees not-ready for the whole reset window.
  assign in_ready  = rst_n && (state == ST_IDLE);
  assign state_out = work;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      work      <= '0;
      col_cnt   <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            work    <= state_in;
            col_cnt <= '0;
            state   <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          work    <= work_next;
          col_cnt <= col_cnt + STEP;
          if (col_cnt == LAST_BASE) begin
            state     <= ST_DONE;
            out_valid <= 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_inv_mix_columns_iter.sv
`default_nettype none
// ============================================================================
// Module  : tb_inv_mix_columns_iter
// Purpose : Self-checking bench for inv_mix_columns_iter. Three instances
//           (1, 2 and 4 columns per cycle) share clock and reset; each has
//           its own handshake signals. A reference model of the AES matrix
//           products feeds a per-instance scoreboard checked every cycle.
// Ports   : none
// Rev     : 1.0  initial release
// ============================================================================
module tb_inv_mix_columns_iter;

  localparam int NC [3] = '{1, 2, 4};

  localparam logic [127:0] FULL_IN  = 128'h8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8;
  localparam logic [127:0] FULL_OUT = 128'hdb135345_f20a225c_d4d4d4d5_2d26314c;

  localparam logic [31:0] COL_IN  [6] = '{32'h8e4da1bc, 32'h9fdc589d, 32'h01010101,
                                          32'hc6c6c6c6, 32'hd5d5d7d6, 32'h4d7ebdf8};
  localparam logic [31:0] COL_OUT [6] = '{32'hdb135345, 32'hf20a225c, 32'h01010101,
                                          32'hc6c6c6c6, 32'hd4d4d4d5, 32'h2d26314c};

  localparam logic [7:0] INV_M [4][4] = '{'{8'h0e, 8'h0b, 8'h0d, 8'h09},
                                          '{8'h09, 8'h0e, 8'h0b, 8'h0d},
                                          '{8'h0d, 8'h09, 8'h0e, 8'h0b},
                                          '{8'h0b, 8'h0d, 8'h09, 8'h0e}};
  localparam logic [7:0] FWD_M [4][4] = '{'{8'h02, 8'h03, 8'h01, 8'h01},
                                          '{8'h01, 8'h02, 8'h03, 8'h01},
                                          '{8'h01, 8'h01, 8'h02, 8'h03},
                                          '{8'h03, 8'h01, 8'h01, 8'h02}};

  typedef struct {
    logic [127:0] din;
    logic [127:0] model;
    logic [127:0] lit;
    bit           has_lit;
    int           acc_edge;
  } entry_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid  [3];
  logic         in_ready  [3];
  logic [127:0] state_in  [3];
  logic         out_valid [3];
  logic         out_ready [3];
  logic [127:0] state_out [3];
  logic [127:0] lit_exp   [3];
  bit           lit_en    [3];

  entry_t sb [3][$];
  int     cyc = 0;
  int     errors = 0;
  int     checks = 0;
  int     stim_timeouts = 0;
  bit     stim_done = 0;
  bit     prod_done = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  inv_mix_columns_iter #(.COLS_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .state_in(state_in[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .state_out(state_out[0]));
  inv_mix_columns_iter #(.COLS_PER_CYCLE(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .state_in(state_in[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .state_out(state_out[1]));
  inv_mix_columns_iter #(.COLS_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .state_in(state_in[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .state_out(state_out[2]));

  // ---------------- reference model ----------------
  // Carry-less product followed by long division by 0x11B.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
    for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (15'(9'h11B) << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [127:0] mat_apply(input logic [127:0] blk, input bit inverse);
    logic [127:0] res;
    logic [7:0]   acc;
    logic [7:0]   coef;
    res = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        acc = '0;
        for (int k = 0; k < 4; k++) begin
          coef = inverse ? INV_M[r][k] : FWD_M[r][k];
          acc  = acc ^ gmul(coef, blk[127-8*(4*c+k) -: 8]);
        end
        res[127-8*(4*c+r) -: 8] = acc;
      end
    end
    return res;
  endfunction

  function automatic logic [127:0] place(input logic [31:0] col, input int j);
    logic [127:0] blk;
    blk = '0;
    blk[127-32*j -: 32] = col;
    return blk;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- compare process ----------------
  initial begin : monitor
    entry_t       e;
    logic [127:0] t;
    bit           prev_rst;
    bit           prev_ov [3];
    int           idle_cnt [3];

    // Pin the model against hand-computed vectors.
    for (int i = 0; i < 6; i++) begin
      t = mat_apply(place(COL_IN[i], 0), 1'b1);
      chk($sformatf("model_col%0d", i), 128'(t[127:96]), 128'(COL_OUT[i]));
    end
    chk("model_full_inv", mat_apply(FULL_IN, 1'b1), FULL_OUT);
    chk("model_full_fwd", mat_apply(FULL_OUT, 1'b0), FULL_IN);

    prev_rst = 1'b0;
    for (int d = 0; d < 3; d++) begin
      prev_ov[d]  = 1'b0;
      idle_cnt[d] = 0;
    end

    forever begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        if (!rst_n) begin
          chk($sformatf("d%0d reset_in_ready", d), 128'(in_ready[d]), 128'(0));
          chk($sformatf("d%0d reset_out_valid", d), 128'(out_valid[d]), 128'(0));
          chk($sformatf("d%0d reset_state_out", d), state_out[d], 128'(0));
          sb[d].delete();
          prev_ov[d]  = 1'b0;
          idle_cnt[d] = 0;
        end else begin
          if (!prev_rst)
            chk($sformatf("d%0d ready_after_reset", d), 128'(in_ready[d]), 128'(1));
          if (out_valid[d]) begin
            idle_cnt[d] = 0;
            chk($sformatf("d%0d in_ready_in_done", d), 128'(in_ready[d]), 128'(0));
            chk($sformatf("d%0d valid_has_block", d), 128'(sb[d].size() != 0), 128'(1));
            if (sb[d].size() != 0) begin
              e = sb[d][0];
              chk($sformatf("d%0d model_result", d), state_out[d], e.model);
              if (e.has_lit)
                chk($sformatf("d%0d literal_result", d), state_out[d], e.lit);
              if (!prev_ov[d])
                chk($sformatf("d%0d latency", d), 128'(cyc - e.acc_edge), 128'(4 / NC[d]));
              if (out_ready[d]) begin
                t = mat_apply(state_out[d], 1'b0);
                chk($sformatf("d%0d roundtrip", d), t, e.din);
                void'(sb[d].pop_front());
              end
            end
          end else if (sb[d].size() != 0) begin
            idle_cnt[d] = idle_cnt[d] + 1;
            chk($sformatf("d%0d wait_bound", d), 128'(idle_cnt[d] > 64), 128'(0));
            if (idle_cnt[d] > 64) begin
              void'(sb[d].pop_front());
              idle_cnt[d] = 0;
            end
          end
          if (in_valid[d] && in_ready[d]) begin
            e.din      = state_in[d];
            e.model    = mat_apply(state_in[d], 1'b1);
            e.lit      = lit_exp[d];
            e.has_lit  = lit_en[d];
            e.acc_edge = cyc + 1;
            sb[d].push_back(e);
          end
          prev_ov[d] = out_valid[d];
        end
      end
      prev_rst = rst_n;
      if (stim_done) begin
        for (int d = 0; d < 3; d++)
          chk($sformatf("d%0d drained", d), 128'(sb[d].size()), 128'(0));
        chk("stimulus_timeouts", 128'(stim_timeouts), 128'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input int d, input logic [127:0] din,
                      input logic [127:0] lit, input bit has);
    bit ok;
    ok          = 1'b0;
    state_in[d] = din;
    lit_exp[d]  = lit;
    lit_en[d]   = has;
    in_valid[d] = 1'b1;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (in_ready[d]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) stim_timeouts = stim_timeouts + 1;
    @(posedge clk);
    #1;
    in_valid[d] = 1'b0;
    lit_en[d]   = 1'b0;
  endtask

  task automatic drain(input int d);
    bit ok;
    ok           = 1'b0;
    out_ready[d] = 1'b1;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (!out_valid[d] && sb[d].size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) stim_timeouts = stim_timeouts + 1;
    @(posedge clk);
    #1;
  endtask

  task automatic random_run(input int d);
    prod_done = 1'b0;
    fork
      begin
        for (int n = 0; n < 100; n++) begin
          int g;
          g = $urandom_range(0, 3);
          if (g > 0) begin
            repeat (g) @(posedge clk);
            #1;
          end
          send(d, {$urandom(), $urandom(), $urandom(), $urandom()}, '0, 1'b0);
        end
        prod_done = 1'b1;
      end
      begin
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 5000; t++) begin
          @(posedge clk);
          #1;
          out_ready[d] = 1'($urandom_range(0, 1));
          if (prod_done && sb[d].size() == 0 && !out_valid[d]) begin
            ok = 1'b1;
            break;
          end
        end
        if (!ok) stim_timeouts = stim_timeouts + 1;
        out_ready[d] = 1'b1;
      end
    join
  endtask

  initial begin : stimulus
    bit ok;
    for (int d = 0; d < 3; d++) begin
      in_valid[d]  = 1'b0;
      state_in[d]  = '0;
      out_ready[d] = 1'b0;
      lit_exp[d]   = '0;
      lit_en[d]    = 1'b0;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Full block on every width, consumer always ready.
    for (int d = 0; d < 3; d++) begin
      out_ready[d] = 1'b1;
      send(d, FULL_IN, FULL_OUT, 1'b1);
      drain(d);
    end

    // One column at a time, each column position in turn.
    for (int i = 0; i < 6; i++) begin
      send(0, place(COL_IN[i], i % 4), place(COL_OUT[i], i % 4), 1'b1);
      drain(0);
    end

    // Back-pressure: result must hold while inputs churn.
    out_ready[0] = 1'b0;
    send(0, FULL_IN, FULL_OUT, 1'b1);
    ok = 1'b0;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (out_valid[0]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) stim_timeouts = stim_timeouts + 1;
    repeat (10) begin
      @(posedge clk);
      #1;
      in_valid[0] = 1'($urandom_range(0, 1));
      state_in[0] = {$urandom(), $urandom(), $urandom(), $urandom()};
    end
    // New input offered in the same cycle the result is taken.
    @(posedge clk);
    #1;
    out_ready[0] = 1'b1;
    send(0, FULL_OUT, '0, 1'b0);
    drain(0);

    // Reset during the second BUSY cycle discards the block.
    send(0, FULL_IN, FULL_OUT, 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    send(0, FULL_IN, FULL_OUT, 1'b1);
    drain(0);

    // Random traffic with gaps on both sides.
    for (int d = 0; d < 3; d++) begin
      random_run(d);
      drain(d);
    end

    stim_done = 1'b1;
    repeat (5) @(posedge clk);
    $display("FAIL summary_not_reached: got 0 expected 1");
    $fatal(1, "bench did not terminate");
  end

endmodule
`default_nettype wire

// File: doc/inv_mix_columns_iter.md
INV_MIX_COLUMNS_ITER -- requirements
Module: inv_mix_columns_iter

Interface
REQ-001 Parameter COLS_PER_CYCLE, default 1: columns transformed per clock; legal values 1, 2, 4; any other value is an elaboration error.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  state_in holds a block to transform.
REQ-005 in_ready  output  1  block can accept a new input.
REQ-006 state_in  input  128  AES state; byte 0 = [127:120]; column c = [127-32c : 96-32c].
REQ-007 out_valid  output  1  state_out holds a finished result.
REQ-008 out_ready  input  1  consumer takes the result.
REQ-009 state_out  output  128  InvMixColumns(state_in), same byte/column layout as state_in.

Function
REQ-010 The block SHALL compute AES InvMixColumns: each output byte r of column c = XOR over k of GF(2^8) product m[r][k]·s[k][c], with polynomial 0x11B.
REQ-011 Row 0 of the coefficient matrix SHALL be {0E,0B,0D,09}; row r SHALL be row 0 rotated right by r.
REQ-012 FSM states SHALL be IDLE, BUSY and DONE.
REQ-013 in_ready SHALL be 1 only in IDLE.
REQ-014 IDLE->BUSY on an edge with in_valid&in_ready: state_in SHALL be captured into the working register and the column counter cleared.
REQ-015 Each BUSY cycle SHALL transform COLS_PER_CYCLE columns in place, starting at column 0 in ascending order, and advance the counter by COLS_PER_CYCLE.
REQ-016 BUSY->DONE on the edge that writes column 3; latency from the accept edge to out_valid rising SHALL be exactly 4/COLS_PER_CYCLE edges.
REQ-017 In DONE, out_valid=1 and state_out SHALL hold stable until out_ready=1; DONE->IDLE on that edge.
REQ-018 state_out SHALL be driven directly from the working register; its value outside DONE is don't-care for the consumer.
REQ-019 in_valid SHALL be ignored in BUSY and DONE; the captured block SHALL not change.
REQ-020 in_valid and out_ready asserted together in DONE SHALL complete the output only; the new input is accepted no earlier than the next IDLE cycle.
REQ-021 The column counter SHALL be 2 bits wide and is never read outside BUSY; wrap-around SHALL have no effect.

Reset
REQ-022 rst_n low SHALL immediately force IDLE, out_valid=0, working register=0, counter=0, regardless of state (including mid-BUSY).
REQ-023 in_ready SHALL be 0 while rst_n is low and 1 on the first cycle after release.
REQ-024 A block in flight when reset asserts SHALL be discarded, with no out_valid pulse.

Structure
REQ-025 A shared package SHALL hold the reduction polynomial 0x11B, the coefficient row {0E,0B,0D,09} and the FSM state encoding, for reuse by the forward MixColumns path.
REQ-026 One combinational sub-module, inv_mix_single_column (32-bit column in, 32-bit column out), SHALL be instantiated COLS_PER_CYCLE times.
REQ-027 GF multiplication by constants SHALL use xtime chains; no lookup ROMs and no multi-cycle paths.

Verification
REQ-028 Single-column checks (each column in turn, COLS_PER_CYCLE=1): 8e4da1bc->db135345, 9fdc589d->f20a225c, 01010101->01010101, c6c6c6c6->c6c6c6c6, d5d5d7d6->d4d4d4d5, 4d7ebdf8->2d26314c.
REQ-029 Full block 8e4da1bc_9fdc589d_d5d5d7d6_4d7ebdf8 -> db135345_f20a225c_d4d4d4d5_2d26314c, with out_valid rising exactly 4, 2 and 1 edges after accept for COLS_PER_CYCLE = 1, 2 and 4.
REQ-030 Back-pressure: hold out_ready=0 for 10 cycles and toggle in_valid/state_in -> state_out stable, in_ready=0, result unchanged after release.
REQ-031 Reset asserted in the second BUSY cycle -> out_valid stays 0 and in_ready=1 after release; the next block is processed correctly.
REQ-032 Back-to-back: 100 random blocks with random valid/ready gaps -> every output equals the reference-model InvMixColumns result, and MixColumns(output) == input.
